seg_display_scanner: RTL and testbench
======================================

Name: seg_display_scanner

Overview:
- Upstream stage of the hex-to-7-segment decoder on the board display path.
- Captures a 16-bit value from the RISC datapath and time-multiplexes it across four common-anode digits.
- Each refresh slot presents one nibble on hex_out, which feeds the decoder's hex input, and drives the matching active-low anode.
- New values are double-buffered so a digit never shows a mix of old and new data within one scan frame.

Parameters:
REFRESH_DIV, 100000, clocks per digit slot; legal range 2 to 2^CNT_W; 100000 gives a 1 kHz slot rate at 100 MHz.
CNT_W, 17, width of the prescaler counter; must satisfy 2^CNT_W >= REFRESH_DIV.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset; clears all state immediately.
load  input  1  single-cycle strobe; captures data_in into the shadow register.
data_in  input  16  value to display; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
blank  input  1  level input; while 1, all anodes are forced off. Scanning continues underneath.
hex_out  output  4  nibble for the active digit; connects to the decoder's hex input.
an  output  4  active-low anode enables; exactly one bit is 0 unless the digit is blanked.
frame_done  output  1  one-cycle pulse on the clock edge where the scan wraps from digit 3 to digit 0.

Behaviour:
- Reset (asynchronous, active-high):
  - prescaler = 0, state = DIG0, shadow = 0, disp = 0, pending = 0, frame_done = 0.
  - Outputs during and after reset: an = 4'b1110 (4'b1111 if blank = 1), hex_out = 4'h0.
- Prescaler:
  - Counts 0 to REFRESH_DIV-1, then wraps to 0.
  - tick = 1 when the count equals REFRESH_DIV-1.
- State machine:
  - States DIG0, DIG1, DIG2, DIG3.
  - On tick: DIG0→DIG1→DIG2→DIG3→DIG0.
  - With no tick, the state holds.
  - Each digit slot lasts exactly REFRESH_DIV clocks; one frame is 4*REFRESH_DIV clocks.
- Load path:
  - load = 1 → shadow <= data_in and pending <= 1 on that edge.
  - Back-to-back loads: the last one wins.
- Frame boundary (tick while in DIG3):
  - If pending = 1: disp <= shadow and pending <= 0.
  - frame_done is registered high for that one cycle.
- load on the same edge as the frame boundary:
  - disp takes the old shadow value.
  - shadow takes data_in and pending stays 1, so the new value displays from the following frame.
- Outputs:
  - Decoded combinationally from registered state and disp only; no combinational path from load, data_in or the prescaler.
  - hex_out = disp nibble selected by state.
  - an = one-hot-low of state, OR'd with 4'b1111 when blank = 1.
- Latency: load to visible on all digits is 1 cycle to shadow, plus up to one full frame to reach disp.
- Reset mid-frame: the scan restarts at DIG0 with a fresh full slot; shadow and disp are lost (display shows 0000).

Optional Feature:
SEG_LEADING_ZERO_BLANK_EN
- Defined: a digit's anode is forced high (off) if its disp nibble and every higher nibble are 0.
  - Digit 0 is never blanked, so value 0 shows "0".
  - hex_out is unaffected.
  - Example: disp = 16'h00A5 → digits 3 and 2 dark, digits 1 and 0 lit.
- Undefined: all four digits are always lit, except when blank = 1.

Decomposition:
- Shared package/header holds:
  - state encodings DIG0=2'd0 to DIG3=2'd3;
  - the anode one-hot-low lookup (4'b1110, 4'b1101, 4'b1011, 4'b0111);
  - the ANODES_OFF constant 4'b1111.
- One sub-module is natural: seg_refresh_prescaler (parameters REFRESH_DIV and CNT_W; ports clk, reset, tick).
- The top level holds the FSM, the shadow/disp registers and output decode. The decoder is instantiated by the integrator, not inside this block.

Test Plan:
- Release reset with REFRESH_DIV=4 and no load → an = 1110, hex_out = 0. After 4 clocks an = 1101; wraps back to 1110 at clock 16, with frame_done high exactly on that edge.
- load data_in = 16'h1234 in mid-frame → display unchanged until the next DIG3→DIG0 wrap. Then hex_out sequence 4, 3, 2, 1 with an 1110, 1101, 1011, 0111.
- load 16'hABCD then 16'h5678 within the same frame → only 5678 is displayed; ABCD never appears.
- load 16'hBEEF on the exact wrap edge → the next frame still shows the previous value; the frame after that shows BEEF.
- Assert blank for 10 clocks mid-scan → an = 1111 throughout. On release, an matches the uninterrupted scan position (prescaler kept running).
- With SEG_LEADING_ZERO_BLANK_EN, disp = 16'h0000 → only an[0] is ever driven low, showing "0". With disp = 16'h0F00 → digit 3 off, digits 2, 1 and 0 lit (F, 0, 0).

Source files
------------

// File: rtl/seg_display_scanner_pkg.sv
// Shared digit-slot encodings and anode lookup for the seven-segment scanner.
package seg_display_scanner_pkg;

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } dig_e;

    localparam logic [3:0] ANODES_OFF = 4'b1111;

    function automatic logic [3:0] anode_sel(input dig_e dig);
        logic [3:0] an_sel;
        case (dig)
            DIG0:    an_sel = 4'b1110;
            DIG1:    an_sel = 4'b1101;
            DIG2:    an_sel = 4'b1011;
            default: an_sel = 4'b0111;
        endcase
        return an_sel;
    endfunction

endpackage

// File: rtl/seg_display_scanner_prescaler.sv
// Slot-rate prescaler: counts 0..REFRESH_DIV-1 and flags the last count.
// tick is combinational from the counter register, so it never sees input paths.
module seg_refresh_prescaler #(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = 17
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick  = (cnt_q == LAST_CNT);
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_display_scanner.sv
// Four-digit time-multiplexed hex scanner with shadow/display double buffering.
// Define SEG_LEADING_ZERO_BLANK_EN to darken leading zero digits (digit 0 always lit).
module seg_display_scanner
    import seg_display_scanner_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] data_in,
    input  logic        blank,
    output logic [3:0]  hex_out,
    output logic [3:0]  an,
    output logic        frame_done
);

    logic        tick;
    dig_e        state_q;
    dig_e        state_d;
    logic [15:0] shadow_q;
    logic [15:0] disp_q;
    logic        pending_q;
    logic        frame_done_q;
    logic [3:0]  an_lit;

    seg_refresh_prescaler #(
        .REFRESH_DIV (REFRESH_DIV),
        .CNT_W       (CNT_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign state_d = tick ? dig_e'(state_q + 2'd1) : state_q;

    // A load coinciding with the frame wrap must keep pending set so the new
    // shadow value is picked up at the following wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= DIG0;
            shadow_q     <= '0;
            disp_q       <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_done_q <= 1'b0;
            if (load) begin
                shadow_q  <= data_in;
                pending_q <= 1'b1;
            end
            if (tick && (state_q == DIG3)) begin
                frame_done_q <= 1'b1;
                if (pending_q) begin
                    disp_q <= shadow_q;
                    if (!load) begin
                        pending_q <= 1'b0;
                    end
                end
            end
        end
    end

    assign hex_out    = disp_q[{state_q, 2'b00} +: 4];
    assign frame_done = frame_done_q;

`ifdef SEG_LEADING_ZERO_BLANK_EN
    always_comb begin
        an_lit = anode_sel(state_q);
        if ((state_q != DIG0) && ((disp_q >> {state_q, 2'b00}) == 16'h0000)) begin
            an_lit = ANODES_OFF;
        end
    end
`else
    always_comb begin
        an_lit = anode_sel(state_q);
    end
`endif

    assign an = blank ? ANODES_OFF : an_lit;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Scoreboard bench for seg_display_scanner at REFRESH_DIV=4 (16-clock frames).
module tb_seg_display_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] data_in;
    logic        blank;
    logic [3:0]  hex_out;
    logic [3:0]  an;
    logic        frame_done;

    seg_display_scanner #(
        .REFRESH_DIV (4),
        .CNT_W       (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .data_in    (data_in),
        .blank      (blank),
        .hex_out    (hex_out),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [3:0] hex;
        logic       fd;
    } exp_t;

    exp_t        sb[$];
    int          n;
    logic [15:0] exp_disp;
    logic        exp_blank;
    int          n_checks = 0;
    int          n_fail   = 0;

    // Expected outputs for the cycle after edge n since reset release.
    function automatic exp_t model_exp();
        exp_t e;
        int   slot;
        slot  = (n / 4) % 4;
        e.cyc = n;
        e.hex = exp_disp[slot*4 +: 4];
        case (slot)
            0:       e.an = 4'b1110;
            1:       e.an = 4'b1101;
            2:       e.an = 4'b1011;
            default: e.an = 4'b0111;
        endcase
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (slot != 0 && (exp_disp >> (4*slot)) == 16'h0000) e.an = 4'b1111;
`endif
        if (exp_blank) e.an = 4'b1111;
        e.fd = (n > 0) && (n % 16 == 0);
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        n = n + 1;
        #1;
        sb.push_back(model_exp());
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        reset    = 1'b1;
        n        = 0;
        exp_disp = 16'h0000;
        sb.push_back(model_exp());
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic load_val(input logic [15:0] v);
        data_in = v;
        load    = 1'b1;
        step();
        load    = 1'b0;
    endtask

    task automatic step_to_wrap(input logic [15:0] next_disp);
        while (n % 16 != 15) step();
        exp_disp = next_disp;
        step();
    endtask

    task automatic set_blank(input logic b);
        @(negedge clk);
        #1;
        blank     = b;
        exp_blank = b;
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks = n_checks + 1;
            if (an !== e.an || hex_out !== e.hex || frame_done !== e.fd) begin
                n_fail = n_fail + 1;
                $display("FAIL scan_out n=%0d: got an=%b hex=%h fd=%b, expected an=%b hex=%h fd=%b",
                         e.cyc, an, hex_out, frame_done, e.an, e.hex, e.fd);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        load      = 1'b0;
        data_in   = 16'h0000;
        blank     = 1'b0;
        exp_blank = 1'b0;
        exp_disp  = 16'h0000;
        n         = 0;

        // Idle scan from reset: slot rotation and wrap pulse at edge 16.
        do_reset();
        repeat (16) step();

        // Mid-frame load appears only after the next wrap.
        repeat (6) step();
        load_val(16'h1234);
        step_to_wrap(16'h1234);
        repeat (18) step();

        // Back-to-back loads in one frame: last one wins.
        load_val(16'hABCD);
        step();
        load_val(16'h5678);
        step_to_wrap(16'h5678);
        repeat (8) step();

        // Load on the wrap edge: pending 1111 goes out, BEEF waits a frame.
        load_val(16'h1111);
        while (n % 16 != 15) step();
        exp_disp = 16'h1111;
        load_val(16'hBEEF);
        step_to_wrap(16'hBEEF);
        repeat (5) step();

        // Blank mid-scan; scanning continues underneath.
        set_blank(1'b1);
        repeat (10) step();
        set_blank(1'b0);
        repeat (10) step();

        // Leading-zero patterns.
        load_val(16'h0F00);
        step_to_wrap(16'h0F00);
        repeat (16) step();
        load_val(16'h0000);
        step_to_wrap(16'h0000);
        repeat (16) step();

        // Reset mid-frame discards the displayed value and restarts at DIG0.
        load_val(16'h9876);
        step_to_wrap(16'h9876);
        repeat (5) step();
        do_reset();
        repeat (20) step();

        repeat (2) @(negedge clk);
        #1;
        n_checks = n_checks + 1;
        if (sb.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
